// File: rtl/secded_codec.sv
// SEC-DED (extended Hamming) encode and check channels with saturating error counters.
// Latency 1 cycle per channel; in_ready = !out_valid || out_ready, output held while stalled.
module secded_codec #(
    parameter int DATA_W = 11,
    parameter int CNT_W  = 8,
    localparam int R     = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
    localparam int PAR_W = R + 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              enc_in_valid,
    output logic              enc_in_ready,
    input  logic [DATA_W-1:0] enc_in_data,
    output logic              enc_out_valid,
    input  logic              enc_out_ready,
    output logic [DATA_W-1:0] enc_out_data,
    output logic [PAR_W-1:0]  enc_out_parity,
    input  logic              dec_in_valid,
    output logic              dec_in_ready,
    input  logic [DATA_W-1:0] dec_in_data,
    input  logic [PAR_W-1:0]  dec_in_parity,
    output logic              dec_out_valid,
    input  logic              dec_out_ready,
    output logic [DATA_W-1:0] dec_out_data,
    output logic              dec_out_corr,
    output logic              dec_out_uncorr,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam int N = DATA_W + R;

    // Data bits fill the non-power-of-two codeword positions 1..N in ascending order.
    function automatic logic [R-1:0] ham_bits(input logic [DATA_W-1:0] d);
        logic [R-1:0] h;
        int           j;
        h = '0;
        j = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int i = 0; i < R; i++) begin
                    if (pos[i]) h[i] = h[i] ^ d[j];
                end
                j++;
            end
        end
        return h;
    endfunction

    function automatic logic [DATA_W-1:0] flip_mask(input logic [R-1:0] syn);
        logic [DATA_W-1:0] m;
        int                j;
        m = '0;
        j = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (int'(syn) == pos) m[j] = 1'b1;
                j++;
            end
        end
        return m;
    endfunction

    // Encode channel
    logic              enc_vld_q;
    logic [DATA_W-1:0] enc_dat_q;
    logic [PAR_W-1:0]  enc_par_q;
    logic [PAR_W-1:0]  enc_par_d;
    logic [R-1:0]      enc_ham;
    logic              enc_fire;

    assign enc_ham      = ham_bits(enc_in_data);
    assign enc_par_d    = {(^enc_in_data) ^ (^enc_ham), enc_ham};
    assign enc_in_ready = !enc_vld_q || enc_out_ready;
    assign enc_fire     = enc_in_valid && enc_in_ready;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            enc_vld_q <= 1'b0;
            enc_dat_q <= '0;
            enc_par_q <= '0;
        end else begin
            if (enc_in_ready) enc_vld_q <= enc_in_valid;
            if (enc_fire) begin
                enc_dat_q <= enc_in_data;
                enc_par_q <= enc_par_d;
            end
        end
    end

    // Check channel
    logic              dec_vld_q;
    logic [DATA_W-1:0] dec_dat_q;
    logic              dec_corr_q;
    logic              dec_uncorr_q;
    logic [DATA_W-1:0] dec_dat_d;
    logic              dec_corr_d;
    logic              dec_uncorr_d;
    logic [R-1:0]      syn;
    logic              par_odd;
    logic              syn_pow2;
    logic              syn_in;
    logic              dec_fire;

    assign syn      = ham_bits(dec_in_data) ^ dec_in_parity[R-1:0];
    assign par_odd  = (^dec_in_data) ^ (^dec_in_parity);
    assign syn_pow2 = ((syn & (syn - R'(1))) == '0);
    assign syn_in   = (int'(syn) <= N);

    // Only an odd overall parity with a syndrome inside the codeword is a single error.
    assign dec_corr_d   = par_odd && (syn_pow2 || syn_in);
    assign dec_uncorr_d = (syn != '0) && !dec_corr_d;
    assign dec_dat_d    = dec_corr_d ? (dec_in_data ^ flip_mask(syn)) : dec_in_data;

    assign dec_in_ready = !dec_vld_q || dec_out_ready;
    assign dec_fire     = dec_in_valid && dec_in_ready;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dec_vld_q    <= 1'b0;
            dec_dat_q    <= '0;
            dec_corr_q   <= 1'b0;
            dec_uncorr_q <= 1'b0;
        end else begin
            if (dec_in_ready) dec_vld_q <= dec_in_valid;
            if (dec_fire) begin
                dec_dat_q    <= dec_dat_d;
                dec_corr_q   <= dec_corr_d;
                dec_uncorr_q <= dec_uncorr_d;
            end
        end
    end

    // Error counters: clear wins over a same-cycle increment; saturate at all-ones.
    logic [CNT_W-1:0] corr_cnt_q;
    logic [CNT_W-1:0] corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q;
    logic [CNT_W-1:0] uncorr_cnt_d;

    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clr_cnt) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (dec_fire) begin
            if (dec_corr_d && (corr_cnt_q != '1))     corr_cnt_d   = corr_cnt_q + CNT_W'(1);
            if (dec_uncorr_d && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign enc_out_valid  = enc_vld_q;
    assign enc_out_data   = enc_dat_q;
    assign enc_out_parity = enc_par_q;
    assign dec_out_valid  = dec_vld_q;
    assign dec_out_data   = dec_dat_q;
    assign dec_out_corr   = dec_corr_q;
    assign dec_out_uncorr = dec_uncorr_q;
    assign corr_cnt       = corr_cnt_q;
    assign uncorr_cnt     = uncorr_cnt_q;

endmodule

// File: tb/tb_secded_codec.sv
// Directed bench for secded_codec with DATA_W = 11, CNT_W = 8.
module tb_secded_codec;

    localparam int DW = 11;
    localparam int CW = 8;
    localparam int PW = 5;

    logic          clk;
    logic          rstN;
    logic          enc_in_valid;
    logic          enc_in_ready;
    logic [DW-1:0] enc_in_data;
    logic          enc_out_valid;
    logic          enc_out_ready;
    logic [DW-1:0] enc_out_data;
    logic [PW-1:0] enc_out_parity;
    logic          dec_in_valid;
    logic          dec_in_ready;
    logic [DW-1:0] dec_in_data;
    logic [PW-1:0] dec_in_parity;
    logic          dec_out_valid;
    logic          dec_out_ready;
    logic [DW-1:0] dec_out_data;
    logic          dec_out_corr;
    logic          dec_out_uncorr;
    logic          clr_cnt;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;

    secded_codec #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rstN           (rstN),
        .enc_in_valid   (enc_in_valid),
        .enc_in_ready   (enc_in_ready),
        .enc_in_data    (enc_in_data),
        .enc_out_valid  (enc_out_valid),
        .enc_out_ready  (enc_out_ready),
        .enc_out_data   (enc_out_data),
        .enc_out_parity (enc_out_parity),
        .dec_in_valid   (dec_in_valid),
        .dec_in_ready   (dec_in_ready),
        .dec_in_data    (dec_in_data),
        .dec_in_parity  (dec_in_parity),
        .dec_out_valid  (dec_out_valid),
        .dec_out_ready  (dec_out_ready),
        .dec_out_data   (dec_out_data),
        .dec_out_corr   (dec_out_corr),
        .dec_out_uncorr (dec_out_uncorr),
        .clr_cnt        (clr_cnt),
        .corr_cnt       (corr_cnt),
        .uncorr_cnt     (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run;
    int n_fail;
    int exp_corr;
    int exp_uncorr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder from an explicit table of data-bit codeword positions.
    function automatic logic [PW-1:0] par_model(input logic [DW-1:0] d);
        int            dpos [DW] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [PW-1:0] p;
        p = '0;
        for (int j = 0; j < DW; j++)
            for (int i = 0; i < 4; i++)
                if (((dpos[j] >> i) & 1) == 1) p[i] = p[i] ^ d[j];
        p[4] = (^d) ^ (^p[3:0]);
        return p;
    endfunction

    task automatic enc_one(input string tag, input logic [DW-1:0] d, input logic [PW-1:0] ep);
        enc_in_valid  = 1'b1;
        enc_in_data   = d;
        enc_out_ready = 1'b1;
        @(posedge clk); #1;
        enc_in_valid = 1'b0;
        chk({tag, "_vld"}, 32'(enc_out_valid), 32'd1);
        chk({tag, "_dat"}, 32'(enc_out_data), 32'(d));
        chk({tag, "_par"}, 32'(enc_out_parity), 32'(ep));
    endtask

    task automatic dec_one(input string tag, input logic [DW-1:0] d, input logic [PW-1:0] p,
                           input logic [DW-1:0] ed, input logic ec, input logic eu);
        dec_in_valid  = 1'b1;
        dec_in_data   = d;
        dec_in_parity = p;
        dec_out_ready = 1'b1;
        chk({tag, "_rdy"}, 32'(dec_in_ready), 32'd1);
        @(posedge clk); #1;
        dec_in_valid = 1'b0;
        if (ec) exp_corr++;
        if (eu) exp_uncorr++;
        chk({tag, "_vld"}, 32'(dec_out_valid), 32'd1);
        chk({tag, "_dat"}, 32'(dec_out_data), 32'(ed));
        chk({tag, "_corr"}, 32'(dec_out_corr), 32'(ec));
        chk({tag, "_uncorr"}, 32'(dec_out_uncorr), 32'(eu));
        chk({tag, "_ccnt"}, 32'(corr_cnt), 32'(exp_corr));
        chk({tag, "_ucnt"}, 32'(uncorr_cnt), 32'(exp_uncorr));
    endtask

    logic [DW-1:0] rnd;
    logic [PW-1:0] rp;
    logic [15:0]   cw;
    logic [DW-1:0] sv [4];

    initial begin
        n_run = 0; n_fail = 0; exp_corr = 0; exp_uncorr = 0;
        rstN = 1'b0; clr_cnt = 1'b0;
        enc_in_valid = 1'b0; enc_in_data = '0; enc_out_ready = 1'b0;
        dec_in_valid = 1'b0; dec_in_data = '0; dec_in_parity = '0; dec_out_ready = 1'b0;
        sv[0] = 11'h2AA; sv[1] = 11'h0F0; sv[2] = 11'h70F; sv[3] = 11'h001;

        repeat (2) @(posedge clk); #1;
        chk("rst_enc_vld", 32'(enc_out_valid), 32'd0);
        chk("rst_dec_vld", 32'(dec_out_valid), 32'd0);
        chk("rst_enc_par", 32'(enc_out_parity), 32'd0);
        chk("rst_dec_dat", 32'(dec_out_data), 32'd0);
        chk("rst_ccnt", 32'(corr_cnt), 32'd0);
        chk("rst_ucnt", 32'(uncorr_cnt), 32'd0);
        rstN = 1'b1;

        // Encode vectors
        enc_one("enc0", 11'h000, 5'b00000);
        enc_one("enc1", 11'h001, 5'b10011);
        enc_one("enc7ff", 11'h7FF, 5'b11111);
        chk("enc7ff_even", 32'(^{enc_out_data, enc_out_parity}), 32'd0);
        enc_one("enc555", 11'h555, par_model(11'h555));

        // Check channel: single errors everywhere, then double errors
        dec_one("sgl", 11'h001, 5'b00000, 11'h000, 1'b1, 1'b0);
        rnd = 11'($urandom_range(0, 2047));
        rp  = par_model(rnd);
        dec_one("clean", rnd, rp, rnd, 1'b0, 1'b0);
        for (int k = 0; k < DW + PW; k++) begin
            cw = {rp, rnd} ^ (16'h0001 << k);
            dec_one($sformatf("flip%0d", k), cw[10:0], cw[15:11], rnd, 1'b1, 1'b0);
        end
        dec_one("dbl", 11'h003, 5'b00000, 11'h003, 1'b0, 1'b1);
        dec_one("dblpar", 11'h000, 5'b10001, 11'h000, 1'b0, 1'b1);

        // Backpressure on the encode channel
        enc_out_ready = 1'b0;
        enc_in_valid  = 1'b1;
        enc_in_data   = 11'h155;
        @(posedge clk); #1;
        chk("bp_vld", 32'(enc_out_valid), 32'd1);
        chk("bp_rdy", 32'(enc_in_ready), 32'd0);
        enc_in_data = 11'h2AA;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_dat%0d", c), 32'(enc_out_data), 32'h155);
            chk($sformatf("bp_hold_par%0d", c), 32'(enc_out_parity), 32'(par_model(11'h155)));
            chk($sformatf("bp_hold_rdy%0d", c), 32'(enc_in_ready), 32'd0);
        end
        enc_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enc_in_data = sv[i];
            @(posedge clk); #1;
            chk($sformatf("stream_vld%0d", i), 32'(enc_out_valid), 32'd1);
            chk($sformatf("stream_dat%0d", i), 32'(enc_out_data), 32'(sv[i]));
            chk($sformatf("stream_par%0d", i), 32'(enc_out_parity), 32'(par_model(sv[i])));
        end
        enc_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream_drain", 32'(enc_out_valid), 32'd0);

        // Counter saturation and clear priority
        dec_out_ready = 1'b1;
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        chk("clr_ccnt", 32'(corr_cnt), 32'd0);
        chk("clr_ucnt", 32'(uncorr_cnt), 32'd0);
        dec_in_valid = 1'b1; dec_in_data = 11'h001; dec_in_parity = '0;
        repeat (255) @(posedge clk);
        #1;
        chk("sat_255", 32'(corr_cnt), 32'd255);
        repeat (45) @(posedge clk);
        #1;
        chk("sat_300", 32'(corr_cnt), 32'd255);
        chk("sat_ucnt", 32'(uncorr_cnt), 32'd0);
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        chk("clr_prio", 32'(corr_cnt), 32'd0);
        clr_cnt = 1'b0;
        @(posedge clk); #1;
        dec_in_valid = 1'b0;
        chk("after_clr", 32'(corr_cnt), 32'd1);

        // Asynchronous reset while both outputs are stalled
        @(posedge clk); #1;
        dec_out_ready = 1'b0; dec_in_valid = 1'b1; dec_in_data = 11'h001; dec_in_parity = '0;
        enc_out_ready = 1'b0; enc_in_valid = 1'b1; enc_in_data = 11'h7FF;
        @(posedge clk); #1;
        dec_in_valid = 1'b0; enc_in_valid = 1'b0;
        chk("pre_rst_vld", 32'(dec_out_valid), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        chk("arst_dec_vld", 32'(dec_out_valid), 32'd0);
        chk("arst_dec_dat", 32'(dec_out_data), 32'd0);
        chk("arst_dec_corr", 32'(dec_out_corr), 32'd0);
        chk("arst_ccnt", 32'(corr_cnt), 32'd0);
        chk("arst_enc_vld", 32'(enc_out_valid), 32'd0);
        chk("arst_enc_par", 32'(enc_out_parity), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        exp_corr = 0; exp_uncorr = 0;
        dec_one("post_rst", 11'h001, 5'b00000, 11'h000, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/secded_codec.md
# secded_codec

Parametrised SEC-DED (extended Hamming) codec for the protected register and memory paths. It has two independent channels, each with one pipeline register and a valid/ready handshake. The encode channel generates check bits for a DATA_W-bit word. The check channel corrects single-bit errors, flags double-bit errors, and keeps saturating error-event counters for the fault-monitoring logic.

## Interface
- DATA_W, 11: data word width, ≥ 4.
- CNT_W, 8: width of each error counter.
- R (localparam): smallest r with 2^r ≥ DATA_W + r + 1. Equals 4 for DATA_W = 11.
- PAR_W (localparam): R + 1.
- clk  in  1  clock; all state updates on the rising edge.
- rstN  in  1  reset, asynchronous, active-low.
- enc_in_valid / enc_in_ready  in / out  1  encode input handshake.
- enc_in_data  in  DATA_W  word to encode.
- enc_out_valid / enc_out_ready  out / in  1  encode output handshake.
- enc_out_data  out  DATA_W  registered copy of the input word.
- enc_out_parity  out  PAR_W  registered check bits.
- dec_in_valid / dec_in_ready  in / out  1  check input handshake.
- dec_in_data  in  DATA_W  received data bits.
- dec_in_parity  in  PAR_W  received check bits.
- dec_out_valid / dec_out_ready  out / in  1  check output handshake.
- dec_out_data  out  DATA_W  corrected data.
- dec_out_corr  out  1  single error corrected; qualified by dec_out_valid.
- dec_out_uncorr  out  1  uncorrectable error; qualified by dec_out_valid.
- clr_cnt  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  number of accepted words with a correctable error.
- uncorr_cnt  out  CNT_W  number of accepted words with an uncorrectable error.

## Operation
- **Codeword layout.** Positions run 1 to N, where N = DATA_W + R.
  - Power-of-two positions hold the Hamming check bits; position 2^i holds check bit i.
  - Data bit j occupies the j-th non-power-of-two position, in ascending order. Data bit 0 is at position 3, bit 1 at 5, bit 2 at 6, bit 3 at 7, bit 4 at 9.
  - parity[i] for i < R is the XOR of all data bits whose position has bit i set.
  - parity[R] is the XOR of all data bits and parity[0..R-1]. This makes the overall codeword parity even.
- **Encode.** Computed combinationally from enc_in_data and registered on acceptance. There is no dependence on previous outputs.
- **Check.**
  - Syndrome s = (Hamming bits recomputed from dec_in_data) XOR dec_in_parity[R-1:0].
  - p = XOR of all DATA_W + PAR_W received bits.
  - s = 0, p = 0: clean. Data passes unchanged, both flags 0.
  - p = 1, s = 0: parity[R] flipped. Data unchanged, corr = 1.
  - p = 1, s a power of two: a check bit flipped. Data unchanged, corr = 1.
  - p = 1, s a data position ≤ N: that data bit is inverted, corr = 1.
  - p = 1, s > N: uncorr = 1, data unchanged.
  - p = 0, s ≠ 0: double error. uncorr = 1, data unchanged.
  - corr and uncorr are never both 1.
- **Counters.**
  - On each accepted check input (dec_in_valid && dec_in_ready), increment corr_cnt or uncorr_cnt per the computed flags.
  - Counters saturate at 2^CNT_W − 1 and never wrap.
  - clr_cnt takes priority over a same-cycle increment; both counters become 0.

## Timing
- Each channel is a one-entry pipeline register. in_ready = !out_valid || out_ready, so the channel sustains full throughput.
- Latency: an input accepted in cycle t is presented at the output in cycle t+1.
- Output data and flags are held stable while out_valid && !out_ready.
- If a new input is accepted in the same cycle the old output is taken, the register loads the new word and out_valid stays 1.
- out_valid falls only when the output is taken and no new input is accepted in that cycle.
- The two channels are fully independent and may transfer in the same cycle.
- Reset (asynchronous, including mid-transfer):
  - all valid outputs go to 0;
  - all data, parity, flag and counter outputs go to 0;
  - any in-flight word is discarded.
- The first transfer can be accepted on the first rising edge after rstN deasserts.

## Test plan
- Encode, DATA_W = 11: input 0 → parity 5'b00000. Input 11'h001 → parity 5'b10011. Input 11'h7FF → data returned unchanged, and the parity makes the full codeword XOR to 0 (checked by model).
- Single error: dec_in_data = 11'h001, parity = 0 → s = 3, dec_out_data = 0, corr = 1, corr_cnt increments by 1. Repeat for every single-bit flip of a random codeword, including each parity bit: all corrected.
- Double error: flip data bits 0 and 1 of the zero codeword → s = 6, p = 0, uncorr = 1, data = 11'h003, uncorr_cnt increments by 1.
- Backpressure: hold enc_out_ready = 0 for 5 cycles with input valid → enc_in_ready = 0 after the first accept, output stable. Release the ready → back-to-back transfers at 1 per cycle with no loss or duplication.
- Counters: inject 300 single errors with CNT_W = 8 → corr_cnt holds at 255. Assert clr_cnt in the same cycle as an error → count reads 0.
- Reset mid-operation: assert rstN low while dec_out_valid = 1 → all outputs read 0 immediately (asynchronously). After release, the first new word passes with latency 1.
